// File: rtl/uart_tb_transceiver.sv
// Full-duplex UART serial peer: 8N1 by default, 8E1 when PARITY_EN is defined.
// TX uses a level start/busy/clear handshake; RX has a 2-flop synchroniser and mid-bit sampling.
module uart_tb_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx,
  output logic                 ser_tx,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_clear_req,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef PARITY_EN
    TX_PARITY,
`endif
    TX_STOP, TX_CLEAR
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   ser_tx_q, ser_tx_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_clear_q, tx_clear_d;
  logic                   tx_bit_end;

  rx_state_e              rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_s1_q, rx_s2_q;
  logic                   rx_armed_q, rx_armed_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;
  logic                   rx_bit_end;
`ifdef PARITY_EN
  logic                   tx_par_q, tx_par_d;
  logic                   rx_par_q, rx_par_d;
`endif

  assign tx_bit_end = (tx_cnt_q == FULL_M1);
  assign rx_bit_end = (rx_cnt_q == FULL_M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      ser_tx_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_clear_q <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_armed_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
`ifdef PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      ser_tx_q   <= ser_tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_clear_q <= tx_clear_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_armed_q <= rx_armed_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
`ifdef PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
`ifdef PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: if (tx_start && !tx_clear_q) begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
        tx_shift_d = tx_data;
`ifdef PARITY_EN
        tx_par_d   = ^tx_data;
`endif
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
`ifdef PARITY_EN
        if (tx_bit_q == LAST_BIT) tx_state_d = TX_PARITY;
`else
        if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
`endif
      end else tx_cnt_d = tx_cnt_q + CW'(1);
`ifdef PARITY_EN
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_cnt_d   = '0;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
`endif
      TX_STOP: if (tx_bit_end) begin
        tx_state_d = TX_CLEAR;
        tx_cnt_d   = '0;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      TX_CLEAR: if (!tx_start) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Outputs decode the next state so the line and flags change on the same edge as the state.
  always_comb begin
    ser_tx_d   = 1'b1;
    tx_busy_d  = 1'b1;
    tx_clear_d = 1'b0;
    case (tx_state_d)
      TX_START: ser_tx_d = 1'b0;
      TX_DATA:  ser_tx_d = tx_shift_d[0];
`ifdef PARITY_EN
      TX_PARITY: ser_tx_d = tx_par_d;
`endif
      TX_STOP:  ser_tx_d = 1'b1;
      TX_CLEAR: begin
        tx_busy_d  = 1'b0;
        tx_clear_d = 1'b1;
      end
      default:  tx_busy_d = 1'b0;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_armed_d = rx_armed_q;
`ifdef PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      // A start is only accepted once the line has been seen high, so a break cannot retrigger.
      RX_IDLE: begin
        rx_armed_d = rx_armed_q | rx_s2_q;
        if (rx_armed_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      RX_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
`ifdef PARITY_EN
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_PARITY;
`else
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
`endif
      end else rx_cnt_d = rx_cnt_q + CW'(1);
`ifdef PARITY_EN
      RX_PARITY: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
`endif
      RX_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_armed_d = rx_s2_q;
        rx_state_d = RX_IDLE;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = (rx_state_q == RX_STOP) && rx_bit_end;
    rx_data_d  = rx_valid_d ? rx_shift_q : rx_data_q;
`ifdef PARITY_EN
    rx_err_d   = rx_valid_d && (!rx_s2_q || (rx_par_q != ^rx_shift_q));
`else
    rx_err_d   = rx_valid_d && !rx_s2_q;
`endif
  end

  assign ser_tx       = ser_tx_q;
  assign tx_busy      = tx_busy_q;
  assign tx_clear_req = tx_clear_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_err       = rx_err_q;

endmodule

// File: tb/tb_uart_tb_transceiver.sv
// Directed bench for uart_tb_transceiver; TX and RX results checked against scoreboard queues.
module tb_uart_tb_transceiver;

  localparam int unsigned CPB = 16;
`ifdef PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  logic       rx_drv;
  logic       loop_en;
  assign ser_rx = loop_en ? ser_tx : rx_drv;

  uart_tb_transceiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rx_valid_cnt = 0;
  logic [7:0] tx_exp_q[$];
  logic [8:0] rx_exp_q[$];

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f);
    for (int k = 0; k < NB; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(negedge clock);
    end
  endtask

  // TX monitor: samples every bit centre of each frame that appears on ser_tx.
  logic        tx_prev = 1'b1;
  logic [10:0] tx_obs;
  logic [7:0]  tx_exp_b;
  always begin
    @(negedge clock);
    if (!reset && tx_prev === 1'b1 && ser_tx === 1'b0) begin
      tx_obs = '1;
      repeat (CPB / 2 - 1) @(negedge clock);
      tx_obs[0] = ser_tx;
      for (int k = 1; k < NB; k++) begin
        repeat (CPB) @(negedge clock);
        tx_obs[k] = ser_tx;
      end
      if (tx_exp_q.size() == 0) check("tx_unexpected_frame", 32'(tx_obs), 32'h0);
      else begin
        tx_exp_b = tx_exp_q.pop_front();
        check("tx_frame_bits", 32'(tx_obs), 32'(frame_of(tx_exp_b)));
      end
    end
    tx_prev = ser_tx;
  end

  logic [8:0] rx_exp_v;
  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      rx_valid_cnt++;
      if (rx_exp_q.size() == 0) check("rx_unexpected_valid", 32'(rx_data), 32'h1ff);
      else begin
        rx_exp_v = rx_exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(rx_exp_v[7:0]));
        check("rx_err", 32'(rx_err), 32'(rx_exp_v[8]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int n;
  int t0;
  int cnt0;
  logic [10:0] fr;

  initial begin
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_ser_tx", 32'(ser_tx), 32'h1);
      check("rst_tx_busy", 32'(tx_busy), 32'h0);
      check("rst_tx_clear", 32'(tx_clear_req), 32'h0);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_ser_tx", 32'(ser_tx), 32'h1);
    check("post_rst_tx_busy", 32'(tx_busy), 32'h0);
    check("post_rst_rx_data", 32'(rx_data), 32'h0);
    check("post_rst_rx_valid", 32'(rx_valid), 32'h0);

    // TX 0x3D, data changed after capture
    tx_exp_q.push_back(8'h3D);
    tx_data = 8'h3D; tx_start = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (tx_busy !== 1'b1 && n < 2);
    check("tx3d_busy_rise", 32'(tx_busy), 32'h1);
    tx_data = 8'hFF;
    n = 0;
    while (tx_clear_req !== 1'b1 && n < NB * CPB + 20) begin @(negedge clock); n++; end
    check("tx3d_clear_req", 32'(tx_clear_req), 32'h1);
    check("tx3d_busy_fall", 32'(tx_busy), 32'h0);
    check("tx3d_line_idle", 32'(ser_tx), 32'h1);
    tx_start = 1'b0;
    @(negedge clock);
    check("tx3d_clear_drop", 32'(tx_clear_req), 32'h0);
    repeat (2 * CPB) @(negedge clock);

    // TX 0x0F with start held for three frame times
    tx_exp_q.push_back(8'h0F);
    tx_data = 8'h0F; tx_start = 1'b1;
    repeat (3 * NB * CPB) @(negedge clock);
    check("tx0f_clear_held", 32'(tx_clear_req), 32'h1);
    check("tx0f_busy_low", 32'(tx_busy), 32'h0);
    tx_start = 1'b0;
    @(negedge clock);
    check("tx0f_clear_drop", 32'(tx_clear_req), 32'h0);
    check("tx_frames_sent", 32'(tx_exp_q.size()), 32'h0);

    // RX back-to-back 0xAB, 0x40
    rx_exp_q.push_back({1'b0, 8'hAB});
    rx_exp_q.push_back({1'b0, 8'h40});
    cnt0 = rx_valid_cnt;
    send_bits(frame_of(8'hAB));
    send_bits(frame_of(8'h40));
    repeat (CPB) @(negedge clock);
    check("rx_b2b_count", 32'(rx_valid_cnt - cnt0), 32'h2);

    // Short low glitch is rejected
    cnt0 = rx_valid_cnt;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("rx_glitch_none", 32'(rx_valid_cnt - cnt0), 32'h0);

    // Framing error: 0x55 with stop bit low
    rx_exp_q.push_back({1'b1, 8'h55});
    fr = frame_of(8'h55);
    fr[NB-1] = 1'b0;
    send_bits(fr);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clock);

    // Break: one errored 0x00 frame, then silence until the line rises
    rx_exp_q.push_back({1'b1, 8'h00});
    cnt0 = rx_valid_cnt;
    rx_drv = 1'b0;
    repeat (15 * CPB) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("rx_break_count", 32'(rx_valid_cnt - cnt0), 32'h1);
    rx_exp_q.push_back({1'b0, 8'h81});
    send_bits(frame_of(8'h81));
    repeat (CPB) @(negedge clock);

`ifdef PARITY_EN
    rx_exp_q.push_back({1'b1, 8'hC3});
    fr = frame_of(8'hC3);
    fr[9] = ~fr[9];
    send_bits(fr);
    repeat (CPB) @(negedge clock);
`endif

    // Loopback 0x5A
    loop_en = 1'b1;
    @(negedge clock);
    tx_exp_q.push_back(8'h5A);
    rx_exp_q.push_back({1'b0, 8'h5A});
    cnt0 = rx_valid_cnt;
    tx_data = 8'h5A; tx_start = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (tx_busy !== 1'b1 && n < 2);
    check("loop_busy_rise", 32'(tx_busy), 32'h1);
    t0 = cyc;
    n = 0;
    while (rx_valid !== 1'b1 && n < (NB + 2) * CPB) begin @(negedge clock); n++; end
    check("loop_rx_valid", 32'(rx_valid), 32'h1);
    check("loop_latency_in_window",
          32'((cyc - t0) >= int'((NB - 1) * CPB) && (cyc - t0) <= int'(NB * CPB)), 32'h1);
    n = 0;
    while (tx_clear_req !== 1'b1 && n < NB * CPB) begin @(negedge clock); n++; end
    check("loop_clear_req", 32'(tx_clear_req), 32'h1);
    tx_start = 1'b0;
    repeat (2) @(negedge clock);
    loop_en = 1'b0;
    repeat (2 * CPB) @(negedge clock);

    check("tx_scoreboard_empty", 32'(tx_exp_q.size()), 32'h0);
    check("rx_scoreboard_empty", 32'(rx_exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
